stim_capture_ctrl: RTL and testbench
====================================

STIM_CAPTURE_CTRL -- requirements
Module: stim_capture_ctrl

Interface
REQ-001 SHALL have parameter NUM_CYCLES, default 10, number of stimulus/capture steps per run (legal range 2..256).
REQ-002 SHALL have parameter DATA_W, default 2, width of the captured child output.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, run request, sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1, synchronous run cancel.
REQ-007 SHALL have port pattern, input, NUM_CYCLES, per-step stimulus bits, latched on accepted start.
REQ-008 SHALL have port a_o, output, 1, registered stimulus driven to the child datapath input.
REQ-009 SHALL have port b_i, input, DATA_W, registered output of the child datapath.
REQ-010 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle pulse on run completion.
REQ-012 SHALL have port cap_count, output, $clog2(NUM_CYCLES+1), number of results captured in the current/last run.
REQ-013 SHALL have port rd_addr, input, $clog2(NUM_CYCLES), result readback index.
REQ-014 SHALL have port rd_data, output, DATA_W, registered readback data.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE_WAIT, CAPTURE, DONE.
REQ-016 IDLE with start=1 SHALL, at that edge: latch pattern, set step=0, clear cap_count, set a_o=pattern[0], go DRIVE_WAIT.
REQ-017 DRIVE_WAIT SHALL last exactly one cycle (child registers a_o at its end), then go CAPTURE.
REQ-018 CAPTURE SHALL write b_i into result[step] and increment cap_count; if step==NUM_CYCLES-1 go DONE, else step++, a_o=pattern[step+1], go DRIVE_WAIT.
REQ-019 DONE SHALL assert done for exactly one cycle, then go IDLE.
REQ-020 Latency start-accept edge to done high SHALL be 2*NUM_CYCLES+1 cycles.
REQ-021 start while busy SHALL be ignored (no restart, pattern not re-latched).
REQ-022 abort in DRIVE_WAIT or CAPTURE SHALL return to IDLE next edge, no done pulse, a_o=0; results already written and cap_count SHALL be kept.
REQ-023 abort and start both high in IDLE: abort SHALL win; start ignored.
REQ-024 abort in DONE SHALL NOT suppress the done pulse.
REQ-025 a_o SHALL return to 0 on entry to IDLE.
REQ-026 rd_data SHALL equal result[rd_addr] one cycle after rd_addr is presented; rd_addr >= NUM_CYCLES SHALL return 0.
REQ-027 Readback SHALL be legal at any time; same-cycle read/write to one index returns the old value.
REQ-028 step and cap_count SHALL never exceed NUM_CYCLES-1 and NUM_CYCLES respectively.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, a_o 0, busy 0, done 0, cap_count 0, step 0, rd_data 0, all result entries 0, latched pattern 0.
REQ-030 Reset asserted mid-run SHALL discard the run; no done pulse after release.
REQ-031 Reset deassertion SHALL be followed by normal start acceptance on the first edge with start=1.

Structure
REQ-032 Shared package stim_capture_pkg SHALL hold the state enum type and default NUM_CYCLES/DATA_W constants.
REQ-033 Result storage SHALL be a sub-module capture_buf (NUM_CYCLES x DATA_W, one write port, one registered read port, async-reset clear).
REQ-034 Bench SHALL connect a_o/b_i to the existing child register stage (b <= {a,~a}) for integration tests.

Verification
REQ-035 N=10, pattern=10'h2AA, start pulse -> done at cycle 21 after accept; result[even]=2'b01, result[odd]=2'b10; cap_count=10.
REQ-036 pattern=10'h000 then second run pattern=10'h3FF -> all results 2'b01, then all 2'b10; cap_count=10 both runs.
REQ-037 abort asserted in CAPTURE of step 3 -> IDLE next edge, no done, cap_count=4, result[0..3] valid, result[4..9] unchanged.
REQ-038 start pulsed again at cycle 5 of a run -> ignored; single done at cycle 21; pattern from first start used.
REQ-039 rst_n low at cycle 8 of a run -> outputs 0 asynchronously, all rd_data reads 0, no done after release; new start runs normally.
REQ-040 rd_addr=12 with N=10 -> rd_data=0; rd_addr=9 after REQ-035 run -> rd_data=2'b10 one cycle later.

Source files
------------

// File: rtl/stim_capture_pkg.sv
// Shared types and default sizing for the stimulus/capture controller.
// The state enum is shared so other blocks can decode controller state.
package stim_capture_pkg;

  localparam int NUM_CYCLES_DEF = 10;
  localparam int DATA_W_DEF     = 2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DRIVE_WAIT = 2'd1,
    CAPTURE    = 2'd2,
    DONE       = 2'd3
  } state_t;

endpackage

// File: rtl/capture_buf.sv
// Result store: one write port and one registered read port.
// The whole array clears on reset, so it maps to registers rather than block RAM.
module capture_buf #(
  parameter  int DEPTH  = 10,
  parameter  int DATA_W = 2,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // Indices past the populated depth read back as zero; a same-edge write is not visible yet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_reg <= '0;
    end else if (32'(rd_addr) < DEPTH) begin
      rd_data_reg <= mem_reg[rd_addr];
    end else begin
      rd_data_reg <= '0;
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/stim_capture_ctrl.sv
// Drives a per-step stimulus bit into a registered child datapath and
// captures the child's response one cycle later, NUM_CYCLES times per run.
module stim_capture_ctrl
  import stim_capture_pkg::*;
#(
  parameter  int NUM_CYCLES = NUM_CYCLES_DEF,
  parameter  int DATA_W     = DATA_W_DEF,
  localparam int AW         = $clog2(NUM_CYCLES),
  localparam int CW         = $clog2(NUM_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_CYCLES-1:0] pattern,
  output logic                  a_o,
  input  logic [DATA_W-1:0]     b_i,
  output logic                  busy,
  output logic                  done,
  output logic [CW-1:0]         cap_count,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  state_t                state_reg, state_next;
  logic [NUM_CYCLES-1:0] pat_reg, pat_next;
  logic [AW-1:0]         step_reg, step_next;
  logic [CW-1:0]         cap_reg, cap_next;
  logic                  a_reg, a_next;
  logic                  wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pat_reg   <= '0;
      step_reg  <= '0;
      cap_reg   <= '0;
      a_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      pat_reg   <= pat_next;
      step_reg  <= step_next;
      cap_reg   <= cap_next;
      a_reg     <= a_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pat_next   = pat_reg;
    step_next  = step_reg;
    cap_next   = cap_reg;
    a_next     = a_reg;
    wr_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          pat_next   = pattern;
          step_next  = '0;
          cap_next   = '0;
          a_next     = pattern[0];
          state_next = DRIVE_WAIT;
        end
      end
      DRIVE_WAIT: begin
        if (abort) begin
          a_next     = 1'b0;
          state_next = IDLE;
        end else begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        // The response to the current step is stored even when this edge aborts.
        wr_en    = 1'b1;
        cap_next = cap_reg + CW'(1);
        if (abort) begin
          a_next     = 1'b0;
          state_next = IDLE;
        end else if (step_reg == AW'(NUM_CYCLES - 1)) begin
          state_next = DONE;
        end else begin
          step_next  = step_reg + AW'(1);
          a_next     = pat_reg[step_reg + AW'(1)];
          state_next = DRIVE_WAIT;
        end
      end
      DONE: begin
        a_next     = 1'b0;
        state_next = IDLE;
      end
      default: begin
        a_next     = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign a_o       = a_reg;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign cap_count = cap_reg;

  capture_buf #(
    .DEPTH  (NUM_CYCLES),
    .DATA_W (DATA_W)
  ) u_capture_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (step_reg),
    .wr_data (b_i),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_stim_capture_ctrl.sv
// Integration bench: controller wired to the {a,~a} child register stage,
// randomized runs checked against a per-run model of expected results.
module tb_stim_capture_ctrl;

  localparam int N  = 10;
  localparam int DW = 2;
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [N-1:0]  pattern = '0;
  logic          a_o;
  logic [DW-1:0] b;
  logic          busy;
  logic          done;
  logic [CW-1:0] cap_count;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_res [N];

  always #5 clk = ~clk;

  // Child datapath register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) b <= '0;
    else        b <= {a_o, ~a_o};
  end

  stim_capture_ctrl #(.NUM_CYCLES(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .pattern   (pattern),
    .a_o       (a_o),
    .b_i       (b),
    .busy      (busy),
    .done      (done),
    .cap_count (cap_count),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic readback(input string name);
    for (int i = 0; i < N; i++) begin
      rd_addr = AW'(i);
      tick();
      chk($sformatf("%s_rd%0d", name, i), 32'(rd_data), 32'(exp_res[i]));
    end
  endtask

  // One run: abort_c / restart_c name the cycle after accept (1-based) in which
  // abort / a second start is raised; 0 means never.
  task automatic run(input logic [N-1:0] pat, input int abort_c, input int restart_c,
                     input logic [N-1:0] pat2, input string name);
    int   first_done = 0;
    int   pulses = 0;
    int   ao_err = 0;
    int   busy_err = 0;
    int   ncap;
    bit   aborted = 0;
    logic exp_busy;
    start   = 1'b1;
    pattern = pat;
    tick();
    start   = 1'b0;
    pattern = ~pat;
    for (int c = 1; c <= 2 * N + 4; c++) begin
      if (done === 1'b1) begin
        pulses++;
        if (first_done == 0) first_done = c;
      end
      exp_busy = !aborted && (c <= 2 * N + 1);
      if (busy !== exp_busy) busy_err++;
      if (aborted || c > 2 * N + 1) begin
        if (a_o !== 1'b0) ao_err++;
      end else if (c <= 2 * N) begin
        if (a_o !== pat[(c - 1) / 2]) ao_err++;
      end
      abort = (c == abort_c);
      start = (c == restart_c);
      if (start) pattern = pat2;
      tick();
      if (c == abort_c && c <= 2 * N) aborted = 1;
      abort = 1'b0;
      start = 1'b0;
    end
    ncap = aborted ? abort_c / 2 : N;
    for (int i = 0; i < ncap; i++) exp_res[i] = pat[i] ? 2'b10 : 2'b01;
    chk({name, "_done_cycle"}, 32'(first_done), aborted ? 32'd0 : 32'(2 * N + 1));
    chk({name, "_done_pulses"}, 32'(pulses), aborted ? 32'd0 : 32'd1);
    chk({name, "_cap_count"}, 32'(cap_count), 32'(ncap));
    chk({name, "_a_o_errs"}, 32'(ao_err), 32'd0);
    chk({name, "_busy_errs"}, 32'(busy_err), 32'd0);
  endtask

  initial begin
    logic [N-1:0] p;
    int ac;
    int pulses;
    int busy_seen;

    for (int i = 0; i < N; i++) exp_res[i] = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_a_o", 32'(a_o), 32'd0);
    chk("rst_cap", 32'(cap_count), 32'd0);
    chk("rst_rd", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // abort beats start in IDLE
    abort = 1'b1; start = 1'b1; pattern = N'($urandom);
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_start_busy", 32'(busy), 32'd0);
    tick();
    chk("abort_start_busy2", 32'(busy), 32'd0);

    run(10'h2AA, 0, 0, '0, "r2aa");
    readback("r2aa");
    rd_addr = AW'(12);
    tick();
    chk("rd_oob12", 32'(rd_data), 32'd0);
    rd_addr = AW'(9);
    tick();
    chk("rd9", 32'(rd_data), 32'(2'b10));

    run(10'h000, 0, 0, '0, "r000");
    readback("r000");
    run(10'h3FF, 0, 0, '0, "r3ff");
    readback("r3ff");

    run(N'($urandom), 8, 0, '0, "abort_cap3");
    readback("abort_cap3");

    run(N'($urandom), 0, 5, N'($urandom), "restart5");
    readback("restart5");

    run(N'($urandom), 2 * N + 1, 0, '0, "abort_done");
    readback("abort_done");

    for (int k = 0; k < 4; k++) begin
      ac = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2 * N)) : 0;
      run(N'($urandom), ac, 0, '0, $sformatf("rand%0d", k));
      readback($sformatf("rand%0d", k));
    end

    // Reset in the middle of a run
    p = N'($urandom);
    start = 1'b1; pattern = p;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_a_o", 32'(a_o), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_cap", 32'(cap_count), 32'd0);
    chk("midrst_rd", 32'(rd_data), 32'd0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    busy_seen = 0;
    for (int c = 0; c < 2 * N + 4; c++) begin
      tick();
      if (done === 1'b1) pulses++;
      if (busy !== 1'b0) busy_seen++;
    end
    chk("midrst_no_done", 32'(pulses), 32'd0);
    chk("midrst_no_busy", 32'(busy_seen), 32'd0);
    for (int i = 0; i < N; i++) exp_res[i] = '0;
    readback("midrst");

    run(N'($urandom), 0, 0, '0, "after_rst");
    readback("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
